button_led_io: RTL and testbench

- Parametrised push-button / LED front-end that replaces hand-wired `assign LED = ~button` glue in board top levels.
- Synchronises and debounces N raw buttons and produces debounced levels plus one-cycle press/release pulses; the pulses feed the NIOS II PIO inputs.
- Drives M LEDs, each independently in one of four modes selected by PIO-driven control inputs: software, follow, blink, toggle.

---
 rtl/button_led_pkg.sv | 20 ++
 rtl/button_led_io_if.sv | 27 ++
 rtl/button_debounce.sv | 63 ++++++
 rtl/button_led_io.sv | 88 ++++++++
 tb/tb_button_led_io.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_led_pkg.sv
// rtl/button_led_pkg.sv - shared types and helpers for the button/LED front-end
package button_led_pkg;

  // Per-LED drive source selected by the PIO
  typedef enum logic [1:0] {
    LED_MODE_SW     = 2'b00,
    LED_MODE_FOLLOW = 2'b01,
    LED_MODE_BLINK  = 2'b10,
    LED_MODE_TOGGLE = 2'b11
  } led_mode_t;

  // Number of bits needed to hold values 0..value-1 (at least 1)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/button_led_io_if.sv
// rtl/button_led_io_if.sv - button/LED signal bundle between board pins, PIO and front-end
interface button_led_io_if #(
  parameter int N_BUTTONS = 4,
  parameter int N_LEDS    = 4
);

  logic [N_BUTTONS-1:0] button;
  logic [N_BUTTONS-1:0] btn_level;
  logic [N_BUTTONS-1:0] btn_press;
  logic [N_BUTTONS-1:0] btn_release;
  logic [2*N_LEDS-1:0]  led_mode;
  logic [N_LEDS-1:0]    led_sw;
  logic [N_LEDS-1:0]    led;

  // Board/PIO side: drives pins and LED controls, observes button events
  modport master (
    output button, led_mode, led_sw,
    input  btn_level, btn_press, btn_release, led
  );

  // Front-end side
  modport slave (
    input  button, led_mode, led_sw,
    output btn_level, btn_press, btn_release, led
  );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - single-channel synchroniser, polarity fix and debouncer
module button_debounce
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int            CW         = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  // Raw pin level when the button is not pressed
  localparam logic          IDLE_LEVEL = ACTIVE_LOW;

  logic          sync1;
  logic          sync2;
  logic          sync_n;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser; reset loads the not-pressed level so no false press appears
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Normalise to 1 = pressed
  assign sync_n = sync2 ^ ACTIVE_LOW;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (sync_n == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_level   <= sync_n;
        btn_press   <= sync_n;
        btn_release <= ~sync_n;
        cnt         <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_led_io.sv
// rtl/button_led_io.sv - debounced buttons with press/release pulses and four-mode LED drive
module button_led_io
  import button_led_pkg::*;
#(
  parameter int N_BUTTONS         = 4,
  parameter int N_LEDS            = 4,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int BLINK_HALF_PERIOD = 12500000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input logic             clock,
  input logic             reset,
  button_led_io_if.slave  bus
);

  localparam int            BW         = clog2(BLINK_HALF_PERIOD + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

  logic [N_BUTTONS-1:0] level_w;
  logic [N_BUTTONS-1:0] press_w;
  logic [N_BUTTONS-1:0] release_w;
  logic [N_LEDS-1:0]    led_w;
  logic [BW-1:0]        blink_cnt;
  logic                 blink_phase;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BUTTON_ACTIVE_LOW)
    ) u_debounce (
      .clock       (clock),
      .reset       (reset),
      .button      (bus.button[g]),
      .btn_level   (level_w[g]),
      .btn_press   (press_w[g]),
      .btn_release (release_w[g])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.led         = led_w;

  // Shared blink timebase; phase flips on every wrap, independent of LED modes
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_led
    // LEDs beyond the button count wrap onto the button channels
    localparam int J = i % N_BUTTONS;

    logic       tog_q;
    logic       tog_next;
    logic       led_q;
    logic [1:0] mode_bits;

    assign tog_next  = tog_q ^ press_w[J];
    assign mode_bits = bus.led_mode[2*i +: 2];
    assign led_w[i]  = led_q;

    // Toggle state runs in every mode; the LED shows the post-press value so it moves one cycle after the pulse
    always_ff @(posedge clock) begin
      if (reset) begin
        tog_q <= 1'b0;
        led_q <= 1'b0;
      end else begin
        tog_q <= tog_next;
        case (led_mode_t'(mode_bits))
          LED_MODE_SW:     led_q <= bus.led_sw[i];
          LED_MODE_FOLLOW: led_q <= level_w[J];
          LED_MODE_BLINK:  led_q <= blink_phase;
          LED_MODE_TOGGLE: led_q <= tog_next;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_led_io.sv
// tb/tb_button_led_io.sv - self-checking bench for button_led_io
module tb_button_led_io;

  localparam int TB_NB          = 4;
  localparam int TB_NL          = 4;
  localparam int TB_D           = 4;
  localparam int TB_H           = 3;
  localparam bit TB_ACTIVE_LOW  = 1'b1;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  button_led_io_if #(.N_BUTTONS(TB_NB), .N_LEDS(TB_NL)) bus ();

  button_led_io #(
    .N_BUTTONS         (TB_NB),
    .N_LEDS            (TB_NL),
    .DEBOUNCE_CYCLES   (TB_D),
    .BLINK_HALF_PERIOD (TB_H),
    .BUTTON_ACTIVE_LOW (TB_ACTIVE_LOW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a level is accepted once the last D synchronised samples,
  // all taken since the previous change or reset, disagree with it.
  logic [TB_NB-1:0] m_s1, m_s2, m_level, m_press, m_release;
  logic [TB_D-1:0]  m_hist [TB_NB];
  int               m_age  [TB_NB];
  logic [TB_NL-1:0] m_tog, m_led;
  int               m_n;

  always @(posedge clock) begin : ref_model
    logic [TB_NB-1:0] lvl_n;
    logic [TB_NL-1:0] tog_n, led_n;
    logic [TB_D-1:0]  h;
    logic             ph;
    int               a;
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0; m_press <= '0; m_release <= '0;
      m_tog <= '0; m_led <= '0; m_n <= 0;
      for (int c = 0; c < TB_NB; c++) begin
        m_hist[c] <= '0;
        m_age[c]  <= 0;
      end
    end else begin
      ph = ((m_n / TB_H) % 2) == 1;
      for (int i = 0; i < TB_NL; i++) begin
        tog_n[i] = m_tog[i] ^ m_press[i % TB_NB];
        case (bus.led_mode[2*i +: 2])
          2'b00:   led_n[i] = bus.led_sw[i];
          2'b01:   led_n[i] = m_level[i % TB_NB];
          2'b10:   led_n[i] = ph;
          default: led_n[i] = tog_n[i];
        endcase
      end
      for (int c = 0; c < TB_NB; c++) begin
        h = {m_hist[c][TB_D-2:0], m_s2[c]};
        a = (m_age[c] < TB_D) ? m_age[c] + 1 : TB_D;
        lvl_n[c] = m_level[c];
        if (a == TB_D && h == {TB_D{~m_level[c]}}) begin
          lvl_n[c] = ~m_level[c];
          a = 0;
        end
        m_hist[c] <= h;
        m_age[c]  <= a;
      end
      m_level   <= lvl_n;
      m_press   <= lvl_n & ~m_level;
      m_release <= ~lvl_n & m_level;
      m_s2      <= m_s1;
      m_s1      <= TB_ACTIVE_LOW ? ~bus.button : bus.button;
      m_tog     <= tog_n;
      m_led     <= led_n;
      m_n       <= m_n + 1;
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic apply_reset(input logic [2*TB_NL-1:0] mode, input logic [TB_NL-1:0] sw);
    reset        = 1'b1;
    bus.button   = '1;
    bus.led_mode = mode;
    bus.led_sw   = sw;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.button   = '1;
    bus.led_mode = '0;
    bus.led_sw   = '1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.led} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", k,
                 {bus.btn_level, bus.btn_press, bus.btn_release, bus.led});
      end
    end
    reset = 1'b0;
    bus.button[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.btn_level[0] !== (k >= 6) || bus.btn_press[0] !== (k == 6)) begin
        errors++;
        $display("FAIL reset_first_press edge %0d: level=%b press=%b want level=%b press=%b",
                 k, bus.btn_level[0], bus.btn_press[0], k >= 6, k == 6);
      end
    end
  endtask

  task automatic test_bounce();
    int pat [4] = '{3, 1, 3, 8};
    apply_reset('0, '0);
    for (int p = 0; p < 4; p++) begin
      bus.button[1] = (p % 2 == 1);
      for (int k = 0; k < pat[p]; k++) begin
        tick();
        checks++;
        if ({bus.btn_level[1], bus.btn_press[1], bus.btn_release[1]} !== 3'b000 ||
            {bus.btn_level, bus.btn_press, bus.btn_release, bus.led} !== {m_level, m_press, m_release, m_led}) begin
          errors++;
          $display("FAIL bounce_ignored seg %0d: got lvl/pr/rl=%b%b%b want 000", p,
                   bus.btn_level[1], bus.btn_press[1], bus.btn_release[1]);
        end
      end
    end
    bus.button[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (bus.btn_level[1] !== (k >= 6) || bus.btn_press[1] !== (k == 6) || bus.btn_release[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_press edge %0d: level=%b press=%b release=%b", k,
                 bus.btn_level[1], bus.btn_press[1], bus.btn_release[1]);
      end
    end
    bus.button[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.btn_level[1] !== (k < 6) || bus.btn_release[1] !== (k == 6) || bus.btn_press[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_release edge %0d: level=%b press=%b release=%b", k,
                 bus.btn_level[1], bus.btn_press[1], bus.btn_release[1]);
      end
    end
  endtask

  task automatic test_sw_follow();
    apply_reset(8'b01_01_00_00, 4'b0011);
    bus.button[2] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (bus.led[1:0] !== 2'b11 || bus.btn_level[2] !== (k >= 6) || bus.led[2] !== (k >= 7)) begin
        errors++;
        $display("FAIL sw_follow edge %0d: led=%b level2=%b want led[1:0]=11 level2=%b led2=%b",
                 k, bus.led, bus.btn_level[2], k >= 6, k >= 7);
      end
    end
  endtask

  task automatic test_blink();
    logic exp_b;
    apply_reset(8'b00_00_00_10, 4'b0000);
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_b = (((k - 1) / TB_H) % 2) == 1;
      checks++;
      if (bus.led[0] !== exp_b) begin
        errors++;
        $display("FAIL blink edge %0d: led0=%b want %b", k, bus.led[0], exp_b);
      end
    end
  endtask

  task automatic test_toggle();
    logic exp_old, exp_new;
    apply_reset(8'b11_00_00_00, 4'b0000);
    exp_new = 1'b0;
    for (int p = 0; p < 3; p++) begin
      exp_old = exp_new;
      exp_new = ~exp_old;
      bus.button[3] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        checks++;
        if (bus.btn_press[3] !== (k == 6) || bus.led[3] !== ((k >= 7) ? exp_new : exp_old)) begin
          errors++;
          $display("FAIL toggle press %0d edge %0d: press=%b led3=%b want led3=%b", p, k,
                   bus.btn_press[3], bus.led[3], (k >= 7) ? exp_new : exp_old);
        end
      end
      bus.button[3] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        tick();
        checks++;
        if (bus.led[3] !== exp_new) begin
          errors++;
          $display("FAIL toggle hold %0d edge %0d: led3=%b want %b", p, k, bus.led[3], exp_new);
        end
      end
    end
    bus.led_mode[7:6] = 2'b00;
    tick();
    checks++;
    if (bus.led[3] !== 1'b0) begin
      errors++;
      $display("FAIL toggle_to_sw: led3=%b want 0", bus.led[3]);
    end
    bus.led_mode[7:6] = 2'b11;
    tick();
    checks++;
    if (bus.led[3] !== 1'b1) begin
      errors++;
      $display("FAIL toggle_back: led3=%b want 1", bus.led[3]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(8'b00_00_00_00, 4'b1111);
    bus.button[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.led} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: got %h want 0",
               {bus.btn_level, bus.btn_press, bus.btn_release, bus.led});
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.btn_level[0] !== (k >= 6) || bus.btn_press[0] !== (k == 6)) begin
        errors++;
        $display("FAIL reset_mid_redetect edge %0d: level=%b press=%b", k,
                 bus.btn_level[0], bus.btn_press[0]);
      end
    end
  endtask

  task automatic test_random();
    int hold [TB_NB];
    apply_reset('0, '0);
    for (int c = 0; c < TB_NB; c++) hold[c] = 0;
    for (int t = 0; t < 800; t++) begin
      for (int c = 0; c < TB_NB; c++) begin
        if (hold[c] == 0) begin
          bus.button[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 9);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 19) == 0) bus.led_mode = 8'($urandom);
      if ($urandom_range(0, 9) == 0)  bus.led_sw   = 4'($urandom);
      reset = ($urandom_range(0, 249) == 0);
      tick();
      checks++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.led} !== {m_level, m_press, m_release, m_led}) begin
        errors++;
        $display("FAIL random_model cycle %0d: dut lvl=%b pr=%b rl=%b led=%b want lvl=%b pr=%b rl=%b led=%b",
                 t, bus.btn_level, bus.btn_press, bus.btn_release, bus.led,
                 m_level, m_press, m_release, m_led);
      end
      checks++;
      if ((bus.btn_press & bus.btn_release) !== '0) begin
        errors++;
        $display("FAIL random_press_and_release cycle %0d: press=%b release=%b", t,
                 bus.btn_press, bus.btn_release);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.button   = '1;
    bus.led_mode = '0;
    bus.led_sw   = '0;
    test_reset();
    test_bounce();
    test_sw_follow();
    test_blink();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
